// File: rtl/program_counter_pkg.sv
// program_counter_pkg: shared CPU defaults for fetch, register-file and branch logic
package program_counter_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_PC_STEP = 4;
  localparam int DEF_R15_OFS = 8;
  localparam int RESET_VEC = 0;
endpackage

// File: rtl/pc_adder.sv
// pc_adder: W-bit modulo adder with a constant operand
module pc_adder #(
  parameter int W = 8,
  parameter int OFS = 4
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = a + W'(OFS);
endmodule

// File: rtl/program_counter.sv
// program_counter: PC register with sequential/jump next-PC select and R15 read view
module program_counter
  import program_counter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_STEP = DEF_PC_STEP,
  parameter int R15_OFS = DEF_R15_OFS
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              mux_sel,
  input  logic [ADDR_W-1:0] addr_to_jmp_in,
  output logic [ADDR_W-1:0] PC_out,
  output logic [ADDR_W-1:0] R15_out
);
  logic [ADDR_W-1:0] pc, pc_seq, pc_next;
  pc_adder #(.W(ADDR_W), .OFS(PC_STEP)) u_seq (.a(pc), .y(pc_seq));
  pc_adder #(.W(ADDR_W), .OFS(R15_OFS)) u_r15 (.a(pc), .y(R15_out));
  assign pc_next = mux_sel ? addr_to_jmp_in : pc_seq;
  always_ff @(posedge clk_in)
    pc <= rst_in ? ADDR_W'(RESET_VEC) : pc_next;
  assign PC_out = pc;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed and randomized checks against a behavioural PC model
module tb_program_counter;
  logic clk = 0, rst_in = 1, mux_sel = 0;
  logic [7:0] addr_to_jmp_in = 0, PC_out, R15_out;
  int checks = 0, errors = 0;
  int exp_pc = 0;
  bit valid = 0;

  program_counter dut (
    .clk_in(clk), .rst_in(rst_in), .mux_sel(mux_sel),
    .addr_to_jmp_in(addr_to_jmp_in), .PC_out(PC_out), .R15_out(R15_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_in) begin
      exp_pc = 0;
      valid = 1;
    end else if (valid)
      exp_pc = mux_sel ? int'(addr_to_jmp_in) : (exp_pc + 4) % 256;
  end

  always @(negedge clk) if (valid) begin
    checks++;
    if (int'(PC_out) != exp_pc) begin
      errors++;
      $display("FAIL model_pc: got %02h expected %02h", PC_out, exp_pc[7:0]);
    end
    checks++;
    if (int'(R15_out) != (exp_pc + 8) % 256) begin
      errors++;
      $display("FAIL model_r15: got %02h expected %02h", R15_out, 8'((exp_pc + 8) % 256));
    end
  end

  task automatic step(input logic r, input logic s, input logic [7:0] a);
    @(negedge clk);
    rst_in = r;
    mux_sel = s;
    addr_to_jmp_in = a;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] p, input logic [7:0] r15);
    checks++;
    if (PC_out !== p || R15_out !== r15) begin
      errors++;
      $display("FAIL %s: got pc=%02h r15=%02h expected pc=%02h r15=%02h", name, PC_out, R15_out, p, r15);
    end
  endtask

  initial begin
    step(1, 1, 8'h55);
    step(1, 1, 8'h55);
    lit("reset", 8'h00, 8'h08);
    step(0, 0, 8'h00); lit("seq1", 8'h04, 8'h0C);
    step(0, 0, 8'h00); lit("seq2", 8'h08, 8'h10);
    step(0, 0, 8'h00); lit("seq3", 8'h0C, 8'h14);
    step(0, 0, 8'h00); lit("seq4", 8'h10, 8'h18);
    step(0, 1, 8'h80); lit("jump", 8'h80, 8'h88);
    step(0, 0, 8'h00); lit("jump_seq", 8'h84, 8'h8C);
    step(0, 1, 8'hFC); lit("wrap_r15", 8'hFC, 8'h04);
    step(0, 0, 8'h00); lit("wrap0", 8'h00, 8'h08);
    step(0, 0, 8'h00); lit("wrap1", 8'h04, 8'h0C);
    step(0, 1, 8'hF8); lit("r15_wrap", 8'hF8, 8'h00);
    step(0, 1, 8'h33); lit("unaligned", 8'h33, 8'h3B);
    step(0, 0, 8'h00); lit("unaligned_seq", 8'h37, 8'h3F);
    step(0, 1, 8'h40); lit("pre_rst", 8'h40, 8'h48);
    step(1, 1, 8'hA0); lit("mid_rst", 8'h00, 8'h08);
    step(0, 0, 8'h00); lit("post_rst", 8'h04, 8'h0C);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(15) == 0, $urandom_range(3) == 0, 8'($urandom));
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the width of all address ports.
REQ-002 The module SHALL have parameter PC_STEP, default 4, giving the sequential increment in bytes.
REQ-003 The module SHALL have parameter R15_OFS, default 8, giving the offset of R15_out above PC_out.
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  reset; synchronous and active-high.
REQ-006 mux_sel  input  1  next-PC select: 0 = sequential (PC + PC_STEP), 1 = jump (addr_to_jmp_in).
REQ-007 addr_to_jmp_in  input  ADDR_W  branch target address.
REQ-008 PC_out  output  ADDR_W  current program counter, registered.
REQ-009 R15_out  output  ADDR_W  architectural R15 read value (PC_out + R15_OFS), combinational from PC_out.

Function
REQ-010 The block SHALL hold one ADDR_W-bit PC register and no other state.
REQ-011 On each rising clk_in edge with rst_in=0 and mux_sel=0, PC SHALL load (PC + PC_STEP) mod 2^ADDR_W.
REQ-012 On each rising clk_in edge with rst_in=0 and mux_sel=1, PC SHALL load addr_to_jmp_in unmodified, with no alignment masking.
REQ-013 mux_sel and addr_to_jmp_in SHALL be sampled only at the rising edge; the jump takes effect with one-cycle latency (new PC_out visible after that edge).
REQ-014 Increment SHALL wrap modulo 2^ADDR_W: PC=0xFC, mux_sel=0 -> next PC=0x00; no carry/overflow output.
REQ-015 R15_out SHALL equal (PC_out + R15_OFS) mod 2^ADDR_W at all times, with no register stage: PC_out=0xF8 -> R15_out=0x00; PC_out=0xFC -> R15_out=0x04.
REQ-016 PC_out SHALL be driven directly from the PC register (glitch-free, no combinational path from inputs).
REQ-017 X or unknown mux_sel during a non-reset edge is outside the contract; the bench SHALL not drive it.

Reset
REQ-018 When rst_in=1 at a rising clk_in edge, PC SHALL load 0x00 regardless of mux_sel and addr_to_jmp_in (reset has highest priority).
REQ-019 After reset, PC_out SHALL read 0x00 and R15_out SHALL read 0x08.
REQ-020 Reset asserted mid-sequence SHALL discard any pending jump; the first edge with rst_in=0 SHALL then apply the normal next-PC rule from PC=0x00.
REQ-021 PC contents before the first reset edge are undefined; no asynchronous reset path SHALL exist.

Structure
REQ-022 ADDR_W, PC_STEP, R15_OFS defaults and the reset vector constant (0x00) SHALL live in the shared CPU package so the fetch, register-file and branch logic agree.
REQ-023 One sub-module, pc_adder (ADDR_W-bit modulo adder with constant operand), SHALL be instantiated twice: once for PC + PC_STEP, once for PC + R15_OFS.
REQ-024 The next-PC 2:1 mux and the PC register SHALL be inside program_counter itself.

Verification
REQ-025 Reset: rst_in=1 for 2 edges with mux_sel=1, addr_to_jmp_in=0x55 -> PC_out=0x00, R15_out=0x08.
REQ-026 Sequential: after reset, mux_sel=0 for 4 edges -> PC_out 0x04, 0x08, 0x0C, 0x10; R15_out 0x0C, 0x10, 0x14, 0x18.
REQ-027 Jump: PC_out=0x10, mux_sel=1, addr_to_jmp_in=0x80 for one edge, then mux_sel=0 -> PC_out 0x80 then 0x84; R15_out 0x88 then 0x8C.
REQ-028 Wrap: jump to 0xFC, then mux_sel=0 for 2 edges -> PC_out 0x00 then 0x04; R15_out at PC=0xFC is 0x04.
REQ-029 Unaligned jump: addr_to_jmp_in=0x33, mux_sel=1 -> PC_out=0x33; next sequential edge -> 0x37.
REQ-030 Reset mid-run: PC_out=0x40, rst_in=1 with mux_sel=1, addr_to_jmp_in=0xA0 -> PC_out=0x00; release rst_in with mux_sel=0 -> PC_out=0x04.
